// File: rtl/mmio_pwm_if.sv
// Native mem_* bus between a CPU-side master and an MMIO slave.
// The master drives the request; the slave returns a one-cycle ready with read data.
interface mmio_pwm_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mmio_pwm.sv
// Memory-mapped PWM peripheral: DUTY/PERIOD/CTRL/PRESCALE/STATUS in a 32-byte window.
// Optional period-wrap interrupt and sticky STATUS[31] flag when MMIO_PWM_IRQ_EN is defined.
module mmio_pwm #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          CNT_W      = 16,
    parameter int          PRE_W      = 16,
    parameter int          PERIOD_RST = 10
) (
    input  logic       clk,
    input  logic       rst,
    mmio_pwm_if.slave  bus,
    output logic       pwm_out,
    output logic       irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_HOLD
    } bus_state_t;

    typedef enum logic [2:0] {
        OFF_DUTY     = 3'd0,
        OFF_PERIOD   = 3'd1,
        OFF_CTRL     = 3'd2,
        OFF_PRESCALE = 3'd3,
        OFF_STATUS   = 3'd4
    } reg_off_t;

    function automatic logic [31:0] f_merge(
        input logic [31:0] i_old,
        input logic [31:0] i_new,
        input logic [3:0]  i_strb
    );
        logic [31:0] v;
        v = i_old;
        for (int i = 0; i < 4; i++) begin
            if (i_strb[i]) v[8*i +: 8] = i_new[8*i +: 8];
        end
        return v;
    endfunction

    bus_state_t        r_state;
    bus_state_t        w_state_nxt;
    logic [31:0]       r_rdata;
    logic [31:0]       w_rdata_nxt;

    logic [CNT_W-1:0]  r_duty;
    logic [CNT_W-1:0]  r_period;
    logic [1:0]        r_ctrl;
    logic [PRE_W-1:0]  r_prescale;

    logic [PRE_W-1:0]  r_pre_cnt;
    logic [CNT_W-1:0]  r_step;
    logic [CNT_W-1:0]  r_sh_duty;
    logic [CNT_W-1:0]  r_sh_period;
    logic              r_first;
    logic              r_pwm;

    logic              w_hit;
    logic              w_accept;
    logic              w_wr;
    logic [2:0]        w_off;
    logic [31:0]       w_duty_m;
    logic [31:0]       w_period_m;
    logic [31:0]       w_ctrl_m;
    logic [31:0]       w_pre_m;
    logic [31:0]       w_status;
    logic              w_flag;
    logic              w_en;
    logic              w_inv;
    logic              w_tick;
    logic              w_zero_per;
    logic              w_last;
    logic              w_wrap;
    logic              w_reload;
    logic              w_pwm_raw;
    logic              w_unused_ok;

    assign w_hit    = (bus.mem_addr[31:5] == BASE_ADDR[31:5]);
    assign w_accept = bus.mem_valid && w_hit && (r_state == S_IDLE);
    assign w_wr     = w_accept && (bus.mem_wstrb != 4'h0);
    assign w_off    = bus.mem_addr[4:2];

    // Byte lanes within the word; the bottom address bits select nothing.
    assign w_unused_ok = &{1'b0, bus.mem_addr[1:0]};

    // ---------------- bus handshake FSM ----------------
    // NOTE: sequential state uses <= so every register samples pre-edge values in parallel.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: the next-state default comes first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ACK;
            S_ACK:   w_state_nxt = bus.mem_valid ? S_HOLD : S_IDLE;
            S_HOLD:  if (!bus.mem_valid) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.mem_ready = (r_state == S_ACK);
    assign bus.mem_rdata = r_rdata;

    // ---------------- register file ----------------
    assign w_duty_m   = f_merge(32'(r_duty),     bus.mem_wdata, bus.mem_wstrb);
    assign w_period_m = f_merge(32'(r_period),   bus.mem_wdata, bus.mem_wstrb);
    assign w_ctrl_m   = f_merge({30'd0, r_ctrl}, bus.mem_wdata, bus.mem_wstrb);
    assign w_pre_m    = f_merge(32'(r_prescale), bus.mem_wdata, bus.mem_wstrb);
    assign w_status   = 32'(r_step) | {w_flag, 31'd0};

    always_comb begin
        w_rdata_nxt = '0;
        case (w_off)
            OFF_DUTY:     w_rdata_nxt = 32'(r_duty);
            OFF_PERIOD:   w_rdata_nxt = 32'(r_period);
            OFF_CTRL:     w_rdata_nxt = {30'd0, r_ctrl};
            OFF_PRESCALE: w_rdata_nxt = 32'(r_prescale);
            OFF_STATUS:   w_rdata_nxt = w_status;
            default:      w_rdata_nxt = '0;
        endcase
    end

    // Read data is zero outside the ack cycle so a shared bus can OR slaves together.
    always_ff @(posedge clk) begin
        if (rst) r_rdata <= '0;
        else     r_rdata <= w_accept ? w_rdata_nxt : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty     <= '0;
            r_period   <= CNT_W'(PERIOD_RST);
            r_ctrl     <= '0;
            r_prescale <= '0;
        end else if (w_wr) begin
            case (w_off)
                OFF_DUTY:     r_duty     <= w_duty_m[CNT_W-1:0];
                OFF_PERIOD:   r_period   <= w_period_m[CNT_W-1:0];
                OFF_CTRL:     r_ctrl     <= w_ctrl_m[1:0];
                OFF_PRESCALE: r_prescale <= w_pre_m[PRE_W-1:0];
                default:      ;
            endcase
        end
    end

    // ---------------- PWM engine ----------------
    assign w_en       = r_ctrl[0];
    assign w_inv      = r_ctrl[1];
    // >= keeps a shrinking PRESCALE from stalling a counter already past the new limit.
    assign w_tick     = (r_pre_cnt >= r_prescale);
    assign w_zero_per = (r_sh_period == '0);
    assign w_last     = (r_step == r_sh_period - CNT_W'(1));
    assign w_wrap     = w_en && w_tick && !r_first && !w_zero_per && w_last;
    assign w_reload   = w_en && w_tick && (r_first || (!w_zero_per && w_last));
    assign w_pwm_raw  = w_en && !w_zero_per && (r_step < r_sh_duty);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt   <= '0;
            r_step      <= '0;
            r_sh_duty   <= '0;
            r_sh_period <= CNT_W'(PERIOD_RST);
            r_first     <= 1'b1;
            r_pwm       <= 1'b0;
        end else begin
            r_pwm <= w_pwm_raw ^ w_inv;
            if (!w_en) begin
                r_pre_cnt <= '0;
                r_step    <= '0;
                r_first   <= 1'b1;
            end else if (w_zero_per && !r_first) begin
                r_pre_cnt <= '0;
                r_step    <= '0;
            end else if (w_tick) begin
                r_pre_cnt <= '0;
                if (w_reload) begin
                    r_step      <= '0;
                    r_sh_duty   <= r_duty;
                    r_sh_period <= r_period;
                    r_first     <= 1'b0;
                end else begin
                    r_step <= r_step + CNT_W'(1);
                end
            end else begin
                r_pre_cnt <= r_pre_cnt + PRE_W'(1);
            end
        end
    end

    assign pwm_out = r_pwm;

    // ---------------- interrupt ----------------
`ifdef MMIO_PWM_IRQ_EN
    logic r_flag;

    // A wrap on the same edge as a W1C wins, so no period is ever lost.
    always_ff @(posedge clk) begin
        if (rst)
            r_flag <= 1'b0;
        else if (w_wrap)
            r_flag <= 1'b1;
        else if (w_wr && (w_off == OFF_STATUS) && bus.mem_wstrb[3] && bus.mem_wdata[31])
            r_flag <= 1'b0;
    end

    assign w_flag = r_flag;
    assign irq    = r_flag & w_en;
`else
    assign w_flag = 1'b0;
    assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_pwm.sv
// Directed self-checking bench for mmio_pwm: reset, handshake, PWM shapes, boundaries, strobes, IRQ.
// Build with +define+MMIO_PWM_IRQ_EN to exercise the interrupt flag.
module tb_mmio_pwm;

    localparam logic [31:0] A_DUTY     = 32'h1000_0000;
    localparam logic [31:0] A_PERIOD   = 32'h1000_0004;
    localparam logic [31:0] A_CTRL     = 32'h1000_0008;
    localparam logic [31:0] A_PRESCALE = 32'h1000_000C;
    localparam logic [31:0] A_STATUS   = 32'h1000_0010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwm_out;
    logic irq;

    mmio_pwm_if bus();

    mmio_pwm dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .pwm_out (pwm_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Run-length monitor on pwm_out, sampled 1 time unit after each rising clock edge.
    logic mon_prev = 1'b0;
    int   mon_run  = 0;
    int   hi_len   = 0;
    int   lo_len   = 0;
    int   n_rise   = 0;
    int   n_fall   = 0;

    always begin
        @(posedge clk);
        #1;
        if ((pwm_out === 1'b1) == mon_prev) begin
            mon_run++;
        end else begin
            if (mon_prev) begin
                hi_len = mon_run;
                n_fall++;
            end else begin
                lo_len = mon_run;
                n_rise++;
            end
            mon_run  = 1;
            mon_prev = (pwm_out === 1'b1);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata);
        bit got;
        got   = 1'b0;
        rdata = '0;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = strb;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready) begin
                got   = 1'b1;
                rdata = bus.mem_rdata;
            end
        end
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        if (!got) check($sformatf("ack_timeout_%08h", addr), 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] dummy;
        bus_xfer(addr, data, strb, dummy);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        bus_xfer(addr, 32'd0, 4'h0, data);
    endtask

    task automatic wait_edge(input bit rise, input string tag);
        int base;
        int cyc;
        base = rise ? n_rise : n_fall;
        cyc  = 0;
        while (((rise ? n_rise : n_fall) == base) && (cyc < 2000)) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        if (cyc >= 2000) check({tag, "_edge_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (pwm_out === 1'b1) hi++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          hi;
        bit          seen;
        bit          rd_nz;

        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = 4'h0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pwm",   pwm_out,       32'd0);
        check("rst_ready", bus.mem_ready, 32'd0);
        check("rst_rdata", bus.mem_rdata, 32'd0);
        check("rst_irq",   irq,           32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rd(A_PERIOD, d);   check("rst_period",   d, 32'd10);
        rd(A_DUTY, d);     check("rst_duty",     d, 32'd0);
        rd(A_CTRL, d);     check("rst_ctrl",     d, 32'd0);
        rd(A_PRESCALE, d); check("rst_prescale", d, 32'd0);
        rd(A_STATUS, d);   check("rst_status",   d, 32'd0);

        // Held valid: one ack, one cycle wide, never repeated
        bus.mem_valid = 1'b1;
        bus.mem_addr  = A_DUTY;
        bus.mem_wdata = 32'd3;
        bus.mem_wstrb = 4'hF;
        check("hold_ready_pre", bus.mem_ready, 32'd0);
        @(posedge clk);
        #1;
        check("hold_ready_ack", bus.mem_ready, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_no_reack_%0d", i), bus.mem_ready, 32'd0);
        end
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        rd(A_DUTY, d); check("hold_duty", d, 32'd3);

        // Basic waveform: 3 high / 7 low, then 15 / 35 with PRESCALE=4
        wr(A_PERIOD, 32'd10, 4'hF);
        wr(A_PRESCALE, 32'd0, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        wait_edge(1'b1, "p0");
        wait_edge(1'b0, "p0"); check("p0_high", hi_len, 32'd3);
        wait_edge(1'b1, "p0"); check("p0_low",  lo_len, 32'd7);
        wr(A_PRESCALE, 32'd4, 4'hF);
        wait_edge(1'b1, "p4");
        wait_edge(1'b0, "p4"); check("p4_high", hi_len, 32'd15);
        wait_edge(1'b1, "p4"); check("p4_low",  lo_len, 32'd35);

        // Mid-period duty change takes effect at the following period
        wr(A_PRESCALE, 32'd0, 4'hF);
        wait_edge(1'b1, "mid");
        wait_edge(1'b1, "mid");
        wr(A_DUTY, 32'd7, 4'hF);
        wait_edge(1'b0, "mid"); check("mid_cur_high",  hi_len, 32'd3);
        wait_edge(1'b1, "mid"); check("mid_cur_low",   lo_len, 32'd7);
        wait_edge(1'b0, "mid"); check("mid_next_high", hi_len, 32'd7);
        wait_edge(1'b1, "mid"); check("mid_next_low",  lo_len, 32'd3);

        // Duty boundaries and inversion
        wr(A_DUTY, 32'd0, 4'hF);
        repeat (15) @(posedge clk);
        count_high(25, hi); check("duty0_low", hi, 32'd0);
        wr(A_DUTY, 32'd12, 4'hF);
        repeat (15) @(posedge clk);
        count_high(25, hi); check("duty12_high", hi, 32'd25);
        wr(A_CTRL, 32'd3, 4'hF);
        repeat (3) @(posedge clk);
        count_high(25, hi); check("duty12_inv_low", hi, 32'd0);

        // Out-of-window request is ignored entirely
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h2000_0000;
        bus.mem_wdata = 32'd5;
        bus.mem_wstrb = 4'hF;
        seen  = 1'b0;
        rd_nz = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready) seen = 1'b1;
            if (bus.mem_rdata != 32'd0) rd_nz = 1'b1;
        end
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        check("miss_ready", seen,  32'd0);
        check("miss_rdata", rd_nz, 32'd0);
        rd(A_DUTY, d); check("miss_no_alias", d, 32'd12);

        // Byte strobes and field widths
        wr(A_CTRL, 32'd1, 4'b0010);
        rd(A_CTRL, d); check("strb_ctrl_kept", d, 32'd3);
        wr(A_DUTY, 32'hABCD_1234, 4'b0010);
        rd(A_DUTY, d); check("strb_duty_byte1", d, 32'h0000_120C);
        wr(A_PERIOD, 32'hFFFF_FFFF, 4'hF);
        rd(A_PERIOD, d); check("period_width", d, 32'h0000_FFFF);
        wr(A_PERIOD, 32'd10, 4'hF);
        wr(32'h1000_0014, 32'hDEAD_BEEF, 4'hF);
        rd(32'h1000_0014, d); check("unmapped_14", d, 32'd0);
        rd(32'h1000_001C, d); check("unmapped_1c", d, 32'd0);
        rd(32'h1000_0006, d); check("addr_low_bits", d, 32'd10);

        // Interrupt flag
        wr(A_CTRL, 32'd0, 4'hF);
        wr(A_DUTY, 32'd3, 4'hF);
`ifdef MMIO_PWM_IRQ_EN
        wr(A_STATUS, 32'h8000_0000, 4'hF);
        rd(A_STATUS, d); check("irq_pre_status", d, 32'd0);
        check("irq_pre", irq, 32'd0);
        wr(A_PRESCALE, 32'd20, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        check("irq_low_after_en", irq, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (irq === 1'b1) seen = 1'b1;
        end
        check("irq_rise", seen, 32'd1);
        rd(A_STATUS, d); check("irq_status_flag", d[31], 32'd1);
        wr(A_STATUS, 32'h8000_0000, 4'b1000);
        check("irq_w1c", irq, 32'd0);
        rd(A_STATUS, d); check("irq_status_clear", d[31], 32'd0);
`else
        wr(A_PRESCALE, 32'd0, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        repeat (40) @(posedge clk);
        #1;
        check("irq_tied_low", irq, 32'd0);
        rd(A_STATUS, d); check("status_bit31_zero", d[31], 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
